// File: rtl/flash_audio_sched.sv
// flash_audio_sched
// -----------------------------------------------------------------------------
// Schedules the shared read-only SPI flash reader for the S/PDIF path. Audio
// words (32-bit stereo PCM, 16-bit LE L/R) are prefetched from a fixed flash
// window into a small sample FIFO. The FIFO head is handed to the S/PDIF
// encoder on each sample request. An optional secondary word-read requester
// (aux) shares the flash port whenever the audio FIFO has enough margin.
//
// Build option: define AUX_PORT_EN to enable the aux requester. Without it
// the aux inputs are ignored and aux_ready/aux_rdata are tied to zero.
//
// Ports:
//   clk, resetn               system clock, synchronous active-low reset
//   enable                    1 = keep issuing audio fetches
//   flash_valid/flash_addr    read request to the flash reader (addr held)
//   flash_ready/flash_rdata   1-cycle completion pulse with read data
//   sample_req                1-cycle pulse: encoder consumes one sample
//   sample_o                  sample currently presented to the encoder
//   underrun                  1-cycle pulse: sample_req with FIFO empty
//   fifo_level                FIFO occupancy
//   aux_valid/aux_addr        aux word read request (held until aux_ready)
//   aux_ready/aux_rdata       aux completion pulse / data (held)
// -----------------------------------------------------------------------------
module flash_audio_sched #(
    parameter logic [23:0] AUDIO_ADDR = 24'h000000,
    parameter logic [23:0] AUDIO_SIZE = 24'h0ea600,
    parameter int          FIFO_DEPTH = 8,
    parameter int          LOW_WATER  = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    output logic                          flash_valid,
    output logic [23:0]                   flash_addr,
    input  logic                          flash_ready,
    input  logic [31:0]                   flash_rdata,
    input  logic                          sample_req,
    output logic [31:0]                   sample_o,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          aux_valid,
    input  logic [23:0]                   aux_addr,
    output logic                          aux_ready,
    output logic [31:0]                   aux_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [23:0]   LAST_ADDR = AUDIO_ADDR + AUDIO_SIZE - 24'd4;
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LOW_L     = LW'(LOW_WATER);

    typedef enum logic [1:0] {IDLE, AUDIO_RD, AUX_RD} state_t;

    state_t          state_reg, state_next;
    logic            flash_valid_reg;
    logic [23:0]     flash_addr_reg;
    logic [23:0]     fetch_ptr_reg;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic [31:0]     sample_reg;
    logic            underrun_reg;
    logic            push, pop, aux_done, aux_req;
    logic [23:0]     aux_addr_sel;

`ifdef AUX_PORT_EN
    logic            aux_ready_reg;
    logic [31:0]     aux_rdata_reg;

    assign aux_req      = aux_valid;
    assign aux_addr_sel = aux_addr;
    assign aux_ready    = aux_ready_reg;
    assign aux_rdata    = aux_rdata_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aux_ready_reg <= 1'b0;
            aux_rdata_reg <= 32'd0;
        end else begin
            aux_ready_reg <= aux_done;
            if (aux_done)
                aux_rdata_reg <= flash_rdata;
        end
    end
`else
    logic unused_aux;

    // The aux port is compiled out: AUX_RD can never be entered.
    assign aux_req      = 1'b0;
    assign aux_addr_sel = AUDIO_ADDR;
    assign aux_ready    = 1'b0;
    assign aux_rdata    = 32'd0;
    assign unused_aux   = ^{aux_valid, aux_addr, aux_done};
`endif

    // Pops only happen when something is stored; an empty request mutes.
    assign pop = sample_req && (level_reg != '0);

    // Arbitration runs only from IDLE, so every transaction is followed by at
    // least one IDLE cycle and only one read is ever outstanding. The level
    // used here already includes the push of the transaction that just ended.
    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        aux_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && (level_reg < LOW_L))
                    state_next = AUDIO_RD;
                else if (aux_req)
                    state_next = AUX_RD;
                else if (enable && (level_reg < DEPTH_L))
                    state_next = AUDIO_RD;
            end
            AUDIO_RD: begin
                if (flash_ready) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            AUX_RD: begin
                if (flash_ready) begin
                    aux_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            flash_valid_reg <= 1'b0;
            flash_addr_reg  <= AUDIO_ADDR;
            fetch_ptr_reg   <= AUDIO_ADDR;
        end else begin
            state_reg       <= state_next;
            flash_valid_reg <= (state_next != IDLE);
            if (state_reg == IDLE && state_next == AUDIO_RD)
                flash_addr_reg <= fetch_ptr_reg;
            else if (state_reg == IDLE && state_next == AUX_RD)
                flash_addr_reg <= aux_addr_sel;
            if (push)
                fetch_ptr_reg <= (fetch_ptr_reg == LAST_ADDR) ? AUDIO_ADDR
                                                              : fetch_ptr_reg + 24'd4;
        end
    end

    // Sample storage: plain array, no reset, so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= flash_rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            sample_reg   <= 32'd0;
            underrun_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            // A push can never meet a full FIFO: fetches start only below depth.
            if (push && !pop)
                level_reg <= level_reg + LW'(1);
            else if (pop && !push)
                level_reg <= level_reg - LW'(1);
            // Registered read of the head; empty request outputs silence.
            if (sample_req)
                sample_reg <= pop ? mem[rd_ptr_reg] : 32'd0;
            underrun_reg <= sample_req && !pop;
        end
    end

    assign flash_valid = flash_valid_reg;
    assign flash_addr  = flash_addr_reg;
    assign sample_o    = sample_reg;
    assign underrun    = underrun_reg;
    assign fifo_level  = level_reg;

endmodule

// File: tb/tb_flash_audio_sched.sv
// Testbench for flash_audio_sched: a small audio window (4 words) so the
// fetch pointer wraps often, a flash responder with configurable latency and
// a queue-based reference model of FIFO contents, fetch pointer and grants.
module tb_flash_audio_sched;

    localparam logic [23:0] AUDIO_ADDR = 24'h000100;
    localparam logic [23:0] AUDIO_SIZE = 24'h000010;
    localparam int          FIFO_DEPTH = 8;
    localparam int          LOW_WATER  = 2;
    localparam logic [23:0] LAST_ADDR  = AUDIO_ADDR + AUDIO_SIZE - 24'd4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        flash_valid;
    logic [23:0] flash_addr;
    logic        flash_ready = 1'b0;
    logic [31:0] flash_rdata = 32'd0;
    logic        sample_req = 1'b0;
    logic [31:0] sample_o;
    logic        underrun;
    logic [3:0]  fifo_level;
    logic        aux_valid = 1'b0;
    logic [23:0] aux_addr = 24'd0;
    logic        aux_ready;
    logic [31:0] aux_rdata;

    flash_audio_sched #(
        .AUDIO_ADDR (AUDIO_ADDR),
        .AUDIO_SIZE (AUDIO_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LOW_WATER  (LOW_WATER)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .flash_valid (flash_valid),
        .flash_addr  (flash_addr),
        .flash_ready (flash_ready),
        .flash_rdata (flash_rdata),
        .sample_req  (sample_req),
        .sample_o    (sample_o),
        .underrun    (underrun),
        .fifo_level  (fifo_level),
        .aux_valid   (aux_valid),
        .aux_addr    (aux_addr),
        .aux_ready   (aux_ready),
        .aux_rdata   (aux_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [23:0] m_ptr = AUDIO_ADDR;
    logic [23:0] m_addr = AUDIO_ADDR;
    int          m_busy = 0;          // 0 none, 1 audio read, 2 aux read
    logic [31:0] e_sample = 32'd0;
    logic [31:0] e_aux_rdata = 32'd0;
    logic        e_underrun = 1'b0;
    logic        e_aux_ready = 1'b0;

    // Flash responder
    logic [31:0] salt = 32'd0;
    int          lat = 5;
    int          lat_cnt = 0;
    bit          rand_lat = 0;

    function automatic logic [31:0] data_of(input logic [23:0] a);
        return {8'h00, a} ^ salt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, advance the model by the
    // same rules, then compare every output just after the posedge.
    task automatic step(input logic rn, input logic en, input logic sr,
                        input logic av, input logic [23:0] aa);
        int lvl;
        bit busy_before;
        @(negedge clk);
        resetn = rn; enable = en; sample_req = sr; aux_valid = av; aux_addr = aa;
        flash_ready = 1'b0;
        if (!rn)
            lat_cnt = 0;
        else if (flash_valid === 1'b1) begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
                flash_ready = 1'b1;
                flash_rdata = data_of(flash_addr);
                lat_cnt = 0;
                if (rand_lat) lat = $urandom_range(1, 6);
            end
        end

        e_underrun  = 1'b0;
        e_aux_ready = 1'b0;
        if (!rn) begin
            q.delete();
            m_ptr = AUDIO_ADDR; m_addr = AUDIO_ADDR; m_busy = 0;
            e_sample = 32'd0; e_aux_rdata = 32'd0;
        end else begin
            lvl = q.size();
            busy_before = (m_busy != 0);
            if (sr) begin
                if (lvl > 0) e_sample = q.pop_front();
                else begin e_sample = 32'd0; e_underrun = 1'b1; end
            end
            if (busy_before && flash_ready) begin
                if (m_busy == 1) begin
                    q.push_back(data_of(m_addr));
                    m_ptr = (m_ptr == LAST_ADDR) ? AUDIO_ADDR : m_ptr + 24'd4;
                end else begin
                    e_aux_rdata = data_of(m_addr);
                    e_aux_ready = 1'b1;
                end
                m_busy = 0;
            end else if (!busy_before) begin
                if (en && lvl < LOW_WATER) begin m_busy = 1; m_addr = m_ptr; end
`ifdef AUX_PORT_EN
                else if (av) begin m_busy = 2; m_addr = aa; end
`endif
                else if (en && lvl < FIFO_DEPTH) begin m_busy = 1; m_addr = m_ptr; end
            end
        end

        @(posedge clk);
        #1;
        chk("flash_valid", 32'(flash_valid), 32'(m_busy != 0));
        if (m_busy != 0) chk("flash_addr", 32'(flash_addr), 32'(m_addr));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("sample_o", sample_o, e_sample);
        chk("underrun", 32'(underrun), 32'(e_underrun));
        chk("aux_ready", 32'(aux_ready), 32'(e_aux_ready));
        chk("aux_rdata", aux_rdata, e_aux_rdata);
    endtask

    typedef struct {
        int          n;
        logic        en;
        logic        sr;
        int          lvl;
        logic        vld;
        logic [23:0] addr;
        logic [31:0] smp;
        logic        und;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic        en_r;
        logic        sr_r;
        bit          aux_pend;
        logic [23:0] aux_a;

        // Fill from reset, 5-cycle flash latency, rdata = address.
        vecs[0]  = '{1,  1'b1, 1'b0, 0, 1'b1, 24'h000100, 32'h0, 1'b0};
        vecs[1]  = '{5,  1'b1, 1'b0, 1, 1'b0, 24'h0,      32'h0, 1'b0};
        vecs[2]  = '{1,  1'b1, 1'b0, 1, 1'b1, 24'h000104, 32'h0, 1'b0};
        vecs[3]  = '{5,  1'b1, 1'b0, 2, 1'b0, 24'h0,      32'h0, 1'b0};
        vecs[4]  = '{1,  1'b1, 1'b0, 2, 1'b1, 24'h000108, 32'h0, 1'b0};
        vecs[5]  = '{5,  1'b1, 1'b0, 3, 1'b0, 24'h0,      32'h0, 1'b0};
        vecs[6]  = '{1,  1'b1, 1'b0, 3, 1'b1, 24'h00010c, 32'h0, 1'b0};
        vecs[7]  = '{5,  1'b1, 1'b0, 4, 1'b0, 24'h0,      32'h0, 1'b0};
        vecs[8]  = '{1,  1'b1, 1'b0, 4, 1'b1, 24'h000100, 32'h0, 1'b0};   // wrapped
        vecs[9]  = '{23, 1'b1, 1'b0, 8, 1'b0, 24'h0,      32'h0, 1'b0};   // full
        vecs[10] = '{10, 1'b1, 1'b0, 8, 1'b0, 24'h0,      32'h0, 1'b0};   // stays idle
        vecs[11] = '{1,  1'b0, 1'b1, 7, 1'b0, 24'h0,      32'h100, 1'b0};
        vecs[12] = '{1,  1'b0, 1'b1, 6, 1'b0, 24'h0,      32'h104, 1'b0};
        vecs[13] = '{6,  1'b0, 1'b1, 0, 1'b0, 24'h0,      32'h10c, 1'b0};
        vecs[14] = '{1,  1'b0, 1'b1, 0, 1'b0, 24'h0,      32'h0, 1'b1};   // underrun
        vecs[15] = '{1,  1'b0, 1'b0, 0, 1'b0, 24'h0,      32'h0, 1'b0};

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("rst_flash_valid", 32'(flash_valid), 32'd0);
        chk("rst_flash_addr", 32'(flash_addr), 32'(AUDIO_ADDR));
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_sample", sample_o, 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_aux_ready", 32'(aux_ready), 32'd0);
        chk("rst_aux_rdata", aux_rdata, 32'd0);
        $display("txn reset: valid=%0d addr=%h level=%0d", flash_valid, flash_addr, fifo_level);

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                step(1'b1, vecs[i].en, vecs[i].sr, 1'b0, 24'h0);
            chk("vec_level", 32'(fifo_level), 32'(vecs[i].lvl));
            chk("vec_valid", 32'(flash_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) chk("vec_addr", 32'(flash_addr), 32'(vecs[i].addr));
            chk("vec_sample", sample_o, vecs[i].smp);
            chk("vec_underrun", 32'(underrun), 32'(vecs[i].und));
            $display("txn vec %0d: level=%0d valid=%0d addr=%h sample=%h underrun=%0d",
                     i, fifo_level, flash_valid, flash_addr, sample_o, underrun);
        end

        // Level 1 with sample_req coincident with flash_ready.
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("coinc_pre_level", 32'(fifo_level), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("coinc_addr", 32'(flash_addr), 32'h104);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
        chk("coinc_sample", sample_o, 32'h100);
        chk("coinc_level", 32'(fifo_level), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
        chk("coinc_new_head", sample_o, 32'h104);
        chk("coinc_level0", 32'(fifo_level), 32'd0);
        $display("txn coincident push/pop: sample=%h level=%0d", sample_o, fifo_level);

        // enable drops while a fetch is in flight: it still completes.
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("disable_level", 32'(fifo_level), 32'd1);
        chk("disable_valid", 32'(flash_valid), 32'd0);
        $display("txn disable in flight: level=%0d valid=%0d", fifo_level, flash_valid);

        // Reset during AUDIO_RD; pointer restarts at AUDIO_ADDR.
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("resume_addr", 32'(flash_addr), 32'h10c);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("midrst_valid", 32'(flash_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_addr", 32'(flash_addr), 32'(AUDIO_ADDR));
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("postrst_addr", 32'(flash_addr), 32'(AUDIO_ADDR));
        $display("txn reset mid-read: valid=%0d addr=%h", flash_valid, flash_addr);

        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
`ifdef AUX_PORT_EN
        // aux held from level 0: audio first until LOW_WATER, then aux.
        repeat (12) step(1'b1, 1'b1, 1'b0, 1'b1, 24'h123450);
        chk("aux_pre_level", 32'(fifo_level), 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 24'h123450);
        chk("aux_grant_addr", 32'(flash_addr), 32'h123450);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1, 24'h123450);
        step(1'b1, 1'b1, 1'b0, 1'b1, 24'h123450);
        chk("aux_ready_pulse", 32'(aux_ready), 32'd1);
        chk("aux_rdata_val", aux_rdata, 32'h00123450);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("aux_ready_end", 32'(aux_ready), 32'd0);
        chk("aux_rdata_hold", aux_rdata, 32'h00123450);
        $display("txn aux read: rdata=%h", aux_rdata);
`else
        // aux inputs have no effect in this build.
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 24'h123450);
        chk("noaux_valid", 32'(flash_valid), 32'd0);
        chk("noaux_ready", 32'(aux_ready), 32'd0);
        $display("txn aux ignored: valid=%0d", flash_valid);
`endif

        // Randomized traffic against the model.
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        salt = $urandom;
        rand_lat = 1;
        lat = $urandom_range(1, 6);
        en_r = 1'b1;
        aux_pend = 0;
        aux_a = 24'h800000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) en_r = !en_r;
            case (i / 1000)
                0:       sr_r = ($urandom_range(0, 7) == 0);
                1:       sr_r = ($urandom_range(0, 1) == 0);
                default: sr_r = ($urandom_range(0, 3) == 0);
            endcase
            if (!aux_pend && $urandom_range(0, 9) == 0) begin
                aux_pend = 1;
                aux_a = 24'h800000 | (24'($urandom) & 24'h7ffffc);
            end else if (aux_pend && m_busy != 2 && $urandom_range(0, 49) == 0)
                aux_pend = 0;
            step(1'b1, en_r, sr_r, aux_pend, aux_a);
            if (aux_ready) aux_pend = 0;
        end
        $display("txn random: 3000 cycles, final level=%0d", fifo_level);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
